gestor_llamadas: RTL and testbench
==================================

GESTOR_LLAMADAS -- requirements
Module: gestor_llamadas

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-high reset.
REQ-002 Parameters SHALL be as follows, one per line.
- DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before the debounced button changes; legal range is 2..255.
- LOG2_DEPTH, default 2: log2 of the request-queue depth (depth 4).
REQ-003 Ports SHALL be as follows, one per line.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sw_piso  input  2  requested floor (0..3), raw switches.
- btn_llamar  input  1  raw call button, asynchronous to clk.
- llamada_tomada  input  1  consumer (elevator controller) accepts the head request.
- llamada_valida  output  1  the queue is non-empty and a head request is presented.
- llamada_piso  output  2  floor of the head request.
- pendientes  output  LOG2_DEPTH+1  number of queued requests.
- pisos_pendientes  output  4  one-hot OR of queued floors (bit f = floor f queued); used for LEDs.
- desborde  output  1  one-cycle pulse when a request is dropped because the queue is full.

Function
REQ-004 btn_llamar and sw_piso SHALL each pass through a 2-flop synchronizer before any use.
REQ-005 The debouncer SHALL increment its counter on every cycle where the synchronized button differs from the debounced state, and clear the counter whenever they are equal.
REQ-006 When the counter equals DEBOUNCE_CYCLES-1 and the inputs still differ, the debounced state SHALL toggle at the next edge and the counter SHALL clear.
REQ-007 A 0->1 transition of the debounced state SHALL generate exactly one push request, carrying the synchronized sw_piso value in that cycle; a 1->0 transition SHALL generate nothing.
REQ-008 Push SHALL be registered: for a clean press, llamada_valida SHALL rise exactly 3+DEBOUNCE_CYCLES rising edges after btn_llamar rises, provided the queue was empty.
REQ-009 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no push.
REQ-010 The queue SHALL be a FIFO of depth 2^LOG2_DEPTH holding 2-bit floors, with wrap-around read/write pointers.
REQ-011 llamada_piso SHALL show the head entry combinationally from storage; its value is don't-care when llamada_valida=0.
REQ-012 A pop SHALL occur when llamada_valida && llamada_tomada; llamada_tomada SHALL be ignored when the queue is empty.
REQ-013 A push SHALL be accepted when the queue is not full, or when it is full and a pop occurs in the same cycle.
REQ-014 Otherwise the push SHALL be dropped and desborde SHALL pulse high for exactly one cycle.
REQ-015 Simultaneous accepted push and pop SHALL leave pendientes unchanged and advance both pointers.
REQ-016 pendientes SHALL saturate at neither end; it SHALL always equal the true occupancy, 0..2^LOG2_DEPTH.
REQ-017 pisos_pendientes bit f SHALL be 1 iff at least one queued entry equals f, updated in the same cycle as the push/pop that changes it.

Reset
REQ-018 Asserting reset SHALL immediately clear the following: synchronizers, debounced state, debounce counter, pointers, pendientes=0, pisos_pendientes=0, llamada_valida=0, desborde=0.
REQ-019 Reset asserted mid-debounce or with a non-empty queue SHALL discard all pending state.
REQ-020 After reset deassertion, a button already held high SHALL be treated as a new press, following the full debounce and producing one push.
REQ-021 Queue storage contents need not be reset.

Configuration
REQ-022 The macro GESTOR_LLAMADAS_DEDUP_EN SHALL control duplicate suppression.
REQ-023 When GESTOR_LLAMADAS_DEDUP_EN is defined, a push whose floor is already set in pisos_pendientes SHALL be silently dropped, with no desborde pulse.
REQ-024 With GESTOR_LLAMADAS_DEDUP_EN defined, a push SHALL be accepted if its floor equals the entry being popped in the same cycle.
REQ-025 With GESTOR_LLAMADAS_DEDUP_EN defined, a dropped duplicate SHALL have priority over a full-queue drop, so no desborde pulse occurs for it.
REQ-026 When GESTOR_LLAMADAS_DEDUP_EN is not defined, duplicates SHALL be queued normally.

Verification
REQ-027 Clean press: DEBOUNCE_CYCLES=4, sw_piso=2, btn high 20 cycles -> llamada_valida rises on edge 7, llamada_piso=2, pendientes=1, pisos_pendientes=0100.
REQ-028 Glitch rejection: DEBOUNCE_CYCLES=4, btn high 3 cycles, then low -> no push, pendientes stays 0.
REQ-029 Overflow: 5 presses of floors 0,1,2,3,0 (DEDUP off), no llamada_tomada -> pendientes=4, desborde pulses once on the 5th press; pops then return 0,1,2,3.
REQ-030 Full with simultaneous pop: queue full, 5th push coincides with llamada_tomada=1 -> no desborde, pendientes stays 4, head advances.
REQ-031 Dedup (GESTOR_LLAMADAS_DEDUP_EN defined): presses of floors 1,1,3 -> pendientes=2, pisos_pendientes=1010, no desborde.
REQ-032 Reset mid-operation: 3 entries queued plus a press mid-debounce, then reset pulse -> all outputs 0 immediately; with btn still held, one push occurs 3+DEBOUNCE_CYCLES edges after reset deassertion.

Source files
------------

// File: rtl/gestor_llamadas.sv
// Floor-call manager: synchronize + debounce a call button, queue the selected floors in a 2^LOG2_DEPTH FIFO.
// Button edge to llamada_valida is 3+DEBOUNCE_CYCLES cycles; full queue drops with desborde; GESTOR_LLAMADAS_DEDUP_EN drops duplicate floors.

module gestor_llamadas_fifo #(
  parameter int W          = 2,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_vld,
  input  logic [W-1:0]          wr_dat,
  output logic                  wr_rdy,
  output logic                  rd_vld,
  output logic [W-1:0]          rd_dat,
  input  logic                  rd_rdy,
  output logic [LOG2_DEPTH:0]   count
);
  localparam int DEPTH = 2**LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0]   CNT_FULL = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0]   CNT_ONE  = 1;
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = 1;

  logic [W-1:0]          mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr, rd_ptr;
  logic                  wr_en, rd_en;

  assign rd_vld = (count != '0);
  assign rd_en  = rd_vld && rd_rdy;
  // A full queue still takes a write when the head leaves in the same cycle.
  assign wr_rdy = (count != CNT_FULL) || rd_en;
  assign wr_en  = wr_vld && wr_rdy;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en && !rd_en)      count <= count + CNT_ONE;
      else if (rd_en && !wr_en) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end
endmodule

module gestor_llamadas #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOG2_DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            sw_piso,
  input  logic                  btn_llamar,
  input  logic                  llamada_tomada,
  output logic                  llamada_valida,
  output logic [1:0]            llamada_piso,
  output logic [LOG2_DEPTH:0]   pendientes,
  output logic [3:0]            pisos_pendientes,
  output logic                  desborde
);
  localparam logic [7:0]          DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]          DB_ONE  = 8'd1;
  localparam logic [LOG2_DEPTH:0] CNT_ONE = 1;

  logic                btn_s1, btn_s2, deb;
  logic [1:0]          sw_s1, sw_s2;
  logic [7:0]          db_cnt;
  logic                toggle;
  logic                push_req;
  logic [1:0]          push_piso;
  logic                dup, push_vld, push_rdy, push_acc, pop;
  logic [3:0]          inc, dec;
  logic [LOG2_DEPTH:0] floor_cnt [4];

  assign toggle = (btn_s2 != deb) && (db_cnt == DB_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      sw_s1     <= 2'b00;
      sw_s2     <= 2'b00;
      deb       <= 1'b0;
      db_cnt    <= 8'd0;
      push_req  <= 1'b0;
      push_piso <= 2'b00;
      desborde  <= 1'b0;
    end else begin
      btn_s1 <= btn_llamar;
      btn_s2 <= btn_s1;
      sw_s1  <= sw_piso;
      sw_s2  <= sw_s1;
      if (btn_s2 == deb) begin
        db_cnt <= 8'd0;
      end else if (toggle) begin
        deb    <= ~deb;
        db_cnt <= 8'd0;
      end else begin
        db_cnt <= db_cnt + DB_ONE;
      end
      // Only the rising edge of the debounced button raises a call.
      push_req  <= toggle && !deb;
      push_piso <= sw_s2;
      desborde  <= push_req && !dup && !push_rdy;
    end
  end

  assign pop = llamada_valida && llamada_tomada;

`ifdef GESTOR_LLAMADAS_DEDUP_EN
  // A floor already waiting is dropped silently, unless it is the head leaving now.
  assign dup = pisos_pendientes[push_piso] && !(pop && (llamada_piso == push_piso));
`else
  assign dup = 1'b0;
`endif

  assign push_vld = push_req && !dup;
  assign push_acc = push_vld && push_rdy;

  gestor_llamadas_fifo #(
    .W          (2),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (push_vld),
    .wr_dat (push_piso),
    .wr_rdy (push_rdy),
    .rd_vld (llamada_valida),
    .rd_dat (llamada_piso),
    .rd_rdy (llamada_tomada),
    .count  (pendientes)
  );

  // Per-floor occupancy counters keep the LED mask exact with duplicates queued.
  always_comb begin
    inc              = 4'b0000;
    dec              = 4'b0000;
    pisos_pendientes = 4'b0000;
    for (int f = 0; f < 4; f++) begin
      inc[f]              = push_acc && (push_piso == 2'(f));
      dec[f]              = pop && (llamada_piso == 2'(f));
      pisos_pendientes[f] = (floor_cnt[f] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int f = 0; f < 4; f++) floor_cnt[f] <= '0;
    end else begin
      for (int f = 0; f < 4; f++) begin
        if (inc[f] && !dec[f])      floor_cnt[f] <= floor_cnt[f] + CNT_ONE;
        else if (dec[f] && !inc[f]) floor_cnt[f] <= floor_cnt[f] - CNT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_gestor_llamadas.sv
// Randomized and directed bench for gestor_llamadas against a queue-based reference model.
module tb_gestor_llamadas;
  localparam int D     = 4;
  localparam int LD    = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  sw_piso = 2'b00;
  logic        btn_llamar = 1'b0;
  logic        llamada_tomada = 1'b0;
  logic        llamada_valida;
  logic [1:0]  llamada_piso;
  logic [LD:0] pendientes;
  logic [3:0]  pisos_pendientes;
  logic        desborde;

  gestor_llamadas #(.DEBOUNCE_CYCLES(D), .LOG2_DEPTH(LD)) dut (
    .clk              (clk),
    .reset            (reset),
    .sw_piso          (sw_piso),
    .btn_llamar       (btn_llamar),
    .llamada_tomada   (llamada_tomada),
    .llamada_valida   (llamada_valida),
    .llamada_piso     (llamada_piso),
    .pendientes       (pendientes),
    .pisos_pendientes (pisos_pendientes),
    .desborde         (desborde)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int desb_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw sample histories, debounced level, floor queue.
  bit bh[$];
  int sh[$];
  bit m_deb;
  int mq[$];
  bit m_push;
  int m_push_f;
  bit m_ovf;

  task automatic model_reset();
    bh = {};
    sh = {};
    for (int i = 0; i < D + 2; i++) begin
      bh.push_front(1'b0);
      sh.push_front(0);
    end
    m_deb    = 1'b0;
    mq       = {};
    m_push   = 1'b0;
    m_push_f = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_edge();
    bit pop, dup, acc, all_diff;
    if (reset) begin
      model_reset();
      return;
    end
    pop   = (mq.size() > 0) && llamada_tomada;
    dup   = 1'b0;
    acc   = 1'b0;
    m_ovf = 1'b0;
    if (m_push) begin
`ifdef GESTOR_LLAMADAS_DEDUP_EN
      foreach (mq[i]) if (mq[i] == m_push_f && !(pop && i == 0)) dup = 1'b1;
`endif
      if (!dup) begin
        if (mq.size() < DEPTH || pop) acc = 1'b1;
        else m_ovf = 1'b1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(m_push_f);
    // Synchronized value at this edge is the raw value two edges back.
    bh.push_front(btn_llamar);
    sh.push_front(int'(sw_piso));
    while (bh.size() > D + 2) void'(bh.pop_back());
    while (sh.size() > D + 2) void'(sh.pop_back());
    all_diff = 1'b1;
    for (int k = 2; k < D + 2; k++) if (bh[k] == m_deb) all_diff = 1'b0;
    m_push = 1'b0;
    if (all_diff) begin
      m_deb = !m_deb;
      if (m_deb) begin
        m_push   = 1'b1;
        m_push_f = sh[2];
      end
    end
  endtask

  task automatic check_outputs();
    int mask;
    mask = 0;
    foreach (mq[i]) mask = mask | (1 << mq[i]);
    chk("valida", llamada_valida, (mq.size() != 0));
    chk("pendientes", pendientes, mq.size());
    chk("pisos", pisos_pendientes, mask);
    chk("desborde", desborde, m_ovf);
    if (mq.size() != 0) chk("piso", llamada_piso, mq[0]);
    if (desborde === 1'b1) desb_seen++;
  endtask

  task automatic cyc(input bit b, input int s, input bit tk);
    btn_llamar     = b;
    sw_piso        = 2'(s);
    llamada_tomada = tk;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic press(input int f);
    for (int i = 0; i < D + 4; i++) cyc(1'b1, f, 1'b0);
    for (int i = 0; i < D + 4; i++) cyc(1'b0, f, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH; i++) cyc(1'b0, 0, 1'b1);
  endtask

  task automatic async_reset_pulse();
    reset = 1'b1;
    #1;
    chk("rst_valida", llamada_valida, 0);
    chk("rst_pend", pendientes, 0);
    chk("rst_pisos", pisos_pendientes, 0);
    chk("rst_desborde", desborde, 0);
    model_reset();
    cyc(btn_llamar, int'(sw_piso), 1'b0);
    cyc(btn_llamar, int'(sw_piso), 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    int first, d0, run, lvl, fl;
    model_reset();
    #1;
    chk("rst_valida", llamada_valida, 0);
    chk("rst_pend", pendientes, 0);
    chk("rst_pisos", pisos_pendientes, 0);
    chk("rst_desborde", desborde, 0);
    cyc(1'b0, 0, 1'b0);
    cyc(1'b0, 0, 1'b0);
    reset = 1'b0;

    // Clean press: valid rises exactly 3+D edges after the button.
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, 2, 1'b0);
      if (llamada_valida === 1'b1 && first == 0) first = i;
    end
    chk("clean_edge", first, 3 + D);
    chk("clean_piso", llamada_piso, 2);
    chk("clean_pend", pendientes, 1);
    chk("clean_pisos", pisos_pendientes, 4'b0100);
    for (int i = 0; i < D + 4; i++) cyc(1'b0, 2, 1'b0);
    drain();

    // Glitches one cycle shorter than the debounce window.
    for (int i = 0; i < D - 1; i++) cyc(1'b1, 1, 1'b0);
    for (int i = 0; i < D + 6; i++) cyc(1'b0, 1, 1'b0);
    chk("glitch_pend", pendientes, 0);

    // Overflow on the fifth press, then FIFO order.
    d0 = desb_seen;
    press(0); press(1); press(2); press(3); press(0);
    chk("ovf_pend", pendientes, 4);
`ifdef GESTOR_LLAMADAS_DEDUP_EN
    chk("ovf_pulses", desb_seen - d0, 0);
`else
    chk("ovf_pulses", desb_seen - d0, 1);
`endif
    for (int k = 0; k < 4; k++) begin
      chk("pop_order", llamada_piso, k);
      cyc(1'b0, 0, 1'b1);
    end
    chk("pop_empty", pendientes, 0);

    // Full queue with a pop landing on the same edge as the push.
    press(0); press(1); press(2); press(3);
    d0 = desb_seen;
    for (int i = 0; i < D + 4; i++) cyc(1'b1, 0, (i == D + 2));
    for (int i = 0; i < D + 4; i++) cyc(1'b0, 0, 1'b0);
    chk("fullpop_pend", pendientes, 4);
    chk("fullpop_head", llamada_piso, 1);
    chk("fullpop_desb", desb_seen - d0, 0);
    drain();

    // Repeated floor.
    d0 = desb_seen;
    press(1); press(1); press(3);
`ifdef GESTOR_LLAMADAS_DEDUP_EN
    chk("dup_pend", pendientes, 2);
`else
    chk("dup_pend", pendientes, 3);
`endif
    chk("dup_pisos", pisos_pendientes, 4'b1010);
    chk("dup_desb", desb_seen - d0, 0);
    drain();

    // Reset with entries queued and a press mid-debounce; button stays held.
    press(0); press(1); press(2);
    for (int i = 0; i < 3; i++) cyc(1'b1, 3, 1'b0);
    async_reset_pulse();
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, 3, 1'b0);
      if (llamada_valida === 1'b1 && first == 0) first = i;
    end
    chk("rst_repress_edge", first, 3 + D);
    chk("rst_repress_pend", pendientes, 1);
    for (int i = 0; i < D + 4; i++) cyc(1'b0, 3, 1'b0);
    drain();

    // Random runs mixing glitches and real presses.
    lvl = 0;
    fl  = 0;
    for (int n = 0; n < 300; n++) begin
      run = $urandom_range(1, 2 * D + 3);
      lvl = 1 - lvl;
      fl  = $urandom_range(0, 3);
      for (int i = 0; i < run; i++)
        cyc(lvl[0], fl, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 59) == 0) async_reset_pulse();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
